instr_fetch: RTL

Instruction fetch unit that produces the 16-bit instruction words consumed by the instruction register (IR). It owns the program counter and fetches words from program memory over a req/ack handshake with a single outstanding request. It delivers each word with its address to the IR over a valid/ready handshake. It also handles branch redirects and halt.

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch_pc.sv | 40 ++++
 rtl/instr_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared ISA constants (instruction field layout, halt opcode) and the fetch
// state encoding, used by both the fetch unit and the instruction register.
package instr_fetch_pkg;

  localparam int INSTR_W   = 16;
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 10;
  localparam int OP_W      = OP_MSB - OP_LSB + 1;
  localparam int REG_S_BIT = 9;
  localparam int ACC_S_BIT = 8;
  localparam int VAL_MSB   = 7;

  localparam logic [OP_W-1:0] HALT_OP_DEF = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  function automatic logic [OP_W-1:0] op_code(input logic [INSTR_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter register: reset value, +1 step and branch load.
// A redirect load always wins over the increment.
module fetch_pc #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Increment wraps naturally modulo 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding req/ack reads from program memory,
// one-word buffer toward the IR over valid/ready, branch redirect and halt.
//
// Handshakes: memory side keeps mem_req/mem_addr stable until the one-cycle
// mem_ack pulse; IR side keeps instr/instr_pc stable while instr_valid=1 and
// the word moves on a rising edge where instr_valid & instr_ready are both 1.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [OP_W-1:0]   HALT_OP  = HALT_OP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
);

  fetch_state_e       state_q;
  logic               mem_req_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               instr_valid_q;
  logic               halted_q;
  logic               kill_q;

  logic [ADDR_W-1:0]  pc;
  logic               pc_load;
  logic               pc_inc;
  logic               xfer;
  logic               halt_word;
  logic               deliver;
  logic [ADDR_W-1:0]  next_req_addr;

  // A word is only kept when its request was neither killed earlier nor hit
  // by a redirect on the ack cycle itself.
  always_comb begin
    xfer          = instr_valid_q & instr_ready;
    halt_word     = (op_code(instr_q) == HALT_OP);
    deliver       = (state_q == ST_REQ) & mem_ack & ~kill_q & ~br_valid;
    pc_load       = br_valid;
    pc_inc        = deliver;
    next_req_addr = br_valid ? br_target : pc;
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (pc_load),
    .load_pc_i (br_target),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_en) begin
            state_q    <= ST_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= next_req_addr;
          end
        end

        ST_REQ: begin
          if (mem_ack) begin
            kill_q <= 1'b0;
            if (deliver) begin
              instr_q       <= mem_rdata;
              instr_pc_q    <= pc;
              instr_valid_q <= 1'b1;
              mem_req_q     <= 1'b0;
              state_q       <= ST_HOLD;
            end else if (fetch_en) begin
              // Discarded word: chain straight into the redirected request.
              mem_addr_q <= next_req_addr;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end else if (br_valid) begin
            kill_q <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (br_valid || xfer) begin
            instr_valid_q <= 1'b0;
            if (!br_valid && halt_word) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else if (fetch_en) begin
              state_q    <= ST_REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= next_req_addr;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_HALT: begin
          if (br_valid) begin
            halted_q <= 1'b0;
            if (fetch_en) begin
              state_q    <= ST_REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= br_target;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule
